wb_arbiter: RTL and testbench

Writeback arbiter that drives the register file write port. It merges two result streams into the single `rd`/`regWEn`/`DataD` write interface. The streams are single-cycle ALU results, which have fixed priority and no backpressure, and load/store-unit results, which use a valid/ready handshake and are buffered in a small FIFO. The block also exposes the in-flight write for operand forwarding at decode, and raises a stall request when LSU results are starved.

---
 rtl/wb_arbiter_if.sv | 29 ++
 rtl/wb_arbiter.sv | 98 +++++++++
 tb/tb_wb_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU and LSU result streams in, register file write port,
// forwarding compare and stall request out.
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic [4:0]  rd;
    logic        regWEn;
    logic [31:0] DataD;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        fwd_a;
    logic        fwd_b;
    logic        wb_stall;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        output lsu_ready, rd, regWEn, DataD, fwd_a, fwd_b, wb_stall
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, rs1, rs2,
        input  lsu_ready, rd, regWEn, DataD, fwd_a, fwd_b, wb_stall
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win outright, LSU results queue in a small FIFO
// and drain when the ALU is idle; long starvation raises a registered stall request.
module wb_arbiter #(
    parameter int LSU_DEPTH  = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);
    localparam int PW = (LSU_DEPTH > 1) ? $clog2(LSU_DEPTH) : 1;
    localparam int CW = $clog2(LSU_DEPTH + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]  mem_rd   [LSU_DEPTH];
    logic [31:0] mem_data [LSU_DEPTH];

    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          stall_q, stall_d;
    logic [4:0]    rd_q, rd_d;
    logic [31:0]   data_q, data_d;
    logic          wen_q, wen_d;

    logic full, empty, push, pop, alu_sel;

    assign full  = (count_q == CW'(LSU_DEPTH));
    assign empty = (count_q == '0);

    // Ready reflects the start-of-cycle count, so a full FIFO never pushes even while popping.
    assign bus.lsu_ready = !full && !rst;
    assign push    = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);
    assign alu_sel = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign pop     = !alu_sel && !empty;

    always_comb begin
        wptr_d   = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d   = pop  ? rptr_q + 1'b1 : rptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);

        wen_d    = alu_sel || pop;
        rd_d     = rd_q;
        data_d   = data_q;
        if (alu_sel) begin
            rd_d   = bus.alu_rd;
            data_d = bus.alu_data;
        end else if (pop) begin
            rd_d   = mem_rd[rptr_q];
            data_d = mem_data[rptr_q];
        end

        starve_d = starve_q;
        if (pop || empty)
            starve_d = '0;
        else if (alu_sel && starve_q != SW'(STARVE_MAX))
            starve_d = starve_q + 1'b1;

        // Stall latches once the counter has saturated and holds until the head drains.
        stall_d  = !pop && !empty && (stall_q || starve_q == SW'(STARVE_MAX));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wptr_q]   <= bus.lsu_rd;
            mem_data[wptr_q] <= bus.lsu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            rd_q     <= 5'd0;
            data_q   <= 32'd0;
            wen_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            wen_q    <= wen_d;
        end
    end

    assign bus.rd       = rd_q;
    assign bus.DataD    = data_q;
    assign bus.regWEn   = wen_q;
    assign bus.wb_stall = stall_q;
    assign bus.fwd_a    = wen_q && (rd_q == bus.rs1);
    assign bus.fwd_b    = wen_q && (rd_q == bus.rs2);
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a cycle-accurate write scoreboard.
module tb_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int SM    = 8;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if bus();

    wb_arbiter #(.LSU_DEPTH(DEPTH), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wr_t         exp_q[$];
    logic [36:0] fifo_m[$];
    logic [4:0]  last_rd;
    logic [31:0] last_data;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adat;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ldat;
    endtask

    // One clock: predict the write from the driven inputs, advance, compare.
    task automatic step();
        wr_t  e;
        logic ready_m;
        ready_m = !rst && (fifo_m.size() < DEPTH);
        #1;
        chk("lsu_ready", bus.lsu_ready, ready_m);
        if (bus.alu_valid && bus.alu_rd != 5'd0) begin
            e = '{1'b1, bus.alu_rd, bus.alu_data};
        end else if (fifo_m.size() > 0) begin
            e.we = 1'b1;
            {e.rd, e.data} = fifo_m.pop_front();
        end else begin
            e = '{1'b0, last_rd, last_data};
        end
        if (e.we) begin
            last_rd   = e.rd;
            last_data = e.data;
        end
        if (bus.lsu_valid && ready_m && bus.lsu_rd != 5'd0)
            fifo_m.push_back({bus.lsu_rd, bus.lsu_data});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("regWEn", bus.regWEn, e.we);
        chk("rd", bus.rd, e.rd);
        chk("DataD", bus.DataD, e.data);
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0);
        bus.rs1 = 5'd0;
        bus.rs2 = 5'd0;
        last_rd = 5'd0;
        last_data = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regWEn", bus.regWEn, 0);
        chk("rst_rd", bus.rd, 0);
        chk("rst_DataD", bus.DataD, 0);
        chk("rst_stall", bus.wb_stall, 0);
        chk("rst_ready", bus.lsu_ready, 0);
        rst = 1'b0;

        // ALU only, then forwarding compare against the committed write
        drv(1, 5, 32'h1234, 0, 0, 0); step();
        bus.rs1 = 5'd5; bus.rs2 = 5'd6; #1;
        chk("fwd_a_hit", bus.fwd_a, 1);
        chk("fwd_b_miss", bus.fwd_b, 0);
        drv(1, 0, 32'h5555, 0, 0, 0); step();
        chk("fwd_a_nowrite", bus.fwd_a, 0);

        // LSU only: two-cycle latency, rd==0 accepted and dropped
        drv(0, 0, 0, 1, 7, 32'hDEADBEEF); step();
        drv(0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 0, 32'hBAD0BAD0); step();
        drv(0, 0, 0, 0, 0, 0); step();
        step();

        // Collision: ALU first, LSU next cycle; ALU with rd==0 lets the FIFO pop
        drv(1, 3, 32'hA, 1, 4, 32'hB); step();
        drv(0, 0, 0, 0, 0, 0); step();
        drv(0, 0, 0, 1, 9, 32'h99); step();
        drv(1, 0, 32'h77, 0, 0, 0); step();

        // Full FIFO: third entry held until a pop frees a slot
        drv(1, 20, 32'h20, 1, 10, 32'h10); step();
        drv(1, 21, 32'h21, 1, 11, 32'h11); step();
        drv(1, 22, 32'h22, 1, 12, 32'h12); step();
        drv(1, 23, 32'h23, 1, 12, 32'h12); step();
        drv(0, 0, 0, 1, 12, 32'h12); step();
        drv(0, 0, 0, 1, 12, 32'h12); step();
        drv(0, 0, 0, 0, 0, 0); step();
        step();

        // Starvation: stall after SM+1 lost cycles, persists while ALU keeps winning
        chk("stall_idle", bus.wb_stall, 0);
        for (int k = 0; k <= SM + 2; k++) begin
            drv(1, 5'(1 + k), 32'h100 + k, k == 0, 15, 32'h15);
            step();
            chk($sformatf("stall_k%0d", k), bus.wb_stall, (k >= SM + 1));
        end
        drv(0, 0, 0, 0, 0, 0); step();
        chk("stall_clear", bus.wb_stall, 0);

        // Reset mid-drain with two entries queued
        drv(1, 2, 32'h2, 1, 16, 32'h16); step();
        drv(1, 3, 32'h3, 1, 17, 32'h17); step();
        drv(0, 0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_regWEn", bus.regWEn, 0);
        chk("mid_rst_rd", bus.rd, 0);
        chk("mid_rst_DataD", bus.DataD, 0);
        chk("mid_rst_ready", bus.lsu_ready, 0);
        fifo_m.delete();
        last_rd = 5'd0;
        last_data = 32'd0;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        step();
        drv(1, 31, 32'hCAFE, 0, 0, 0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
